input_route_buffer: RTL and testbench

// - Per-port input stage directly upstream of the switch: one instance per switch input port (PORT_NUM copies).
// - Buffers incoming flits in a DEPTH-entry circular FIFO.
// - Computes each flit's output direction (dimension-ordered X->Y->Z on a 3D mesh) at enqueue time and stores it beside the flit.
// - Presents head flit + ROUTE_LEN-bit route to the switch; dequeues when the switch grants.

---
 rtl/input_route_buffer_pkg.sv | 23 ++
 rtl/input_route_buffer_if.sv | 15 +
 rtl/input_route_buffer_route_compute.sv | 22 ++
 rtl/input_route_buffer.sv | 48 ++++
 tb/tb_input_route_buffer.sv | 126 ++++++++++++
 5 files changed

// File: rtl/input_route_buffer_pkg.sv
// input_route_buffer_pkg: shared widths, depth, flit field offsets and direction codes
package input_route_buffer_pkg;
  localparam int FLIT_SIZE = 82;
  localparam int ROUTE_LEN = 3;
  localparam int DEPTH = 5;
  localparam int COORD_W = 4;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int ENTRY_W = FLIT_SIZE + ROUTE_LEN;
  localparam int DST_X_MSB = FLIT_SIZE - 1;
  localparam int DST_Y_MSB = FLIT_SIZE - 1 - COORD_W;
  localparam int DST_Z_MSB = FLIT_SIZE - 1 - 2 * COORD_W;
  typedef enum logic [ROUTE_LEN-1:0] {
    DIR_INJECT = 3'd0,
    DIR_XPOS   = 3'd1,
    DIR_YPOS   = 3'd2,
    DIR_ZPOS   = 3'd3,
    DIR_XNEG   = 3'd4,
    DIR_YNEG   = 3'd5,
    DIR_ZNEG   = 3'd6,
    DIR_EJECT  = 3'd7
  } dir_e;
endpackage

// File: rtl/input_route_buffer_if.sv
// input_route_buffer_if: link-side push and switch-side head/grant signals of one input port
interface input_route_buffer_if;
  import input_route_buffer_pkg::*;
  logic [FLIT_SIZE-1:0] in;
  logic                 in_valid;
  logic                 in_ready;
  logic [FLIT_SIZE-1:0] out;
  logic [ROUTE_LEN-1:0] route_out;
  logic                 out_valid;
  logic                 sw_avail;
  logic [CNT_W-1:0]     count;
  logic                 ovf_err;
  modport master (output in, in_valid, sw_avail, input in_ready, out, route_out, out_valid, count, ovf_err);
  modport slave (input in, in_valid, sw_avail, output in_ready, out, route_out, out_valid, count, ovf_err);
endinterface

// File: rtl/input_route_buffer_route_compute.sv
// route_compute: dimension-ordered X->Y->Z direction for a destination relative to this router
module route_compute
  import input_route_buffer_pkg::*;
#(
  parameter int cur_x = 0,
  parameter int cur_y = 0,
  parameter int cur_z = 0
) (
  input  logic [COORD_W-1:0] dst_x,
  input  logic [COORD_W-1:0] dst_y,
  input  logic [COORD_W-1:0] dst_z,
  output dir_e               route
);
  localparam logic [COORD_W-1:0] CX = COORD_W'(cur_x);
  localparam logic [COORD_W-1:0] CY = COORD_W'(cur_y);
  localparam logic [COORD_W-1:0] CZ = COORD_W'(cur_z);
  // first unresolved dimension decides; all equal means the flit has arrived
  always_comb
    route = dst_x > CX ? DIR_XPOS : dst_x < CX ? DIR_XNEG :
            dst_y > CY ? DIR_YPOS : dst_y < CY ? DIR_YNEG :
            dst_z > CZ ? DIR_ZPOS : dst_z < CZ ? DIR_ZNEG : DIR_EJECT;
endmodule

// File: rtl/input_route_buffer.sv
// input_route_buffer: per-port circular flit FIFO storing a precomputed route beside each flit
module input_route_buffer
  import input_route_buffer_pkg::*;
#(
  parameter int cur_x = 0,
  parameter int cur_y = 0,
  parameter int cur_z = 0
) (
  input logic                 clk,
  input logic                 rst,
  input_route_buffer_if.slave bus
);
  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   cnt;
  logic               ovf, full, push, pop;
  dir_e               route;
  route_compute #(.cur_x(cur_x), .cur_y(cur_y), .cur_z(cur_z)) u_route (
    .dst_x(bus.in[DST_X_MSB -: COORD_W]),
    .dst_y(bus.in[DST_Y_MSB -: COORD_W]),
    .dst_z(bus.in[DST_Z_MSB -: COORD_W]),
    .route(route)
  );
  assign full = cnt == CNT_W'(DEPTH);
  assign push = bus.in_valid & ~full;
  assign pop = bus.out_valid & bus.sw_avail;
  assign bus.in_ready = ~full;
  assign bus.out_valid = cnt != '0;
  assign {bus.route_out, bus.out} = mem[rd_ptr];
  assign bus.count = cnt;
  assign bus.ovf_err = ovf;
  // storage is never cleared; stale entries are hidden by out_valid
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= {route, bus.in};
  // pointers wrap explicitly since DEPTH need not be a power of two
  always_ff @(posedge clk)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr == PTR_W'(DEPTH - 1) ? '0 : wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr == PTR_W'(DEPTH - 1) ? '0 : rd_ptr + 1'b1;
      cnt <= cnt + CNT_W'(push) - CNT_W'(pop);
      ovf <= ovf | (bus.in_valid & full & ~pop);
    end
endmodule

// File: tb/tb_input_route_buffer.sv
// tb_input_route_buffer: scoreboard bench for the per-port route buffer at router (2,2,2)
module tb_input_route_buffer;
  import input_route_buffer_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  logic [ENTRY_W-1:0] sb [$];
  input_route_buffer_if bus ();
  input_route_buffer #(.cur_x(2), .cur_y(2), .cur_z(2)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  function automatic logic [FLIT_SIZE-1:0] mk(input logic [3:0] x, y, z, input logic [15:0] tag);
    return {x, y, z, tag, {3{tag}}, 6'h2a};
  endfunction

  task automatic chk(input string n, input logic [95:0] a, input logic [95:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", n, a, e);
    end
  endtask

  task automatic step(input logic v, input logic [FLIT_SIZE-1:0] f, input logic s);
    bus.in_valid = v;
    bus.in = f;
    bus.sw_avail = s;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [FLIT_SIZE-1:0] f, input logic [2:0] r, input logic s);
    sb.push_back({r, f});
    step(1'b1, f, s);
  endtask

  // monitor: the head shown while the switch grants is consumed at the next edge
  initial forever begin
    @(negedge clk);
    if (!rst && bus.out_valid && bus.sw_avail) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pop got=%0h want=none", {bus.route_out, bus.out});
      end else begin
        logic [ENTRY_W-1:0] e;
        e = sb.pop_front();
        chk("pop_route", 96'(bus.route_out), 96'(e[ENTRY_W-1 -: ROUTE_LEN]));
        chk("pop_flit", 96'(bus.out), 96'(e[FLIT_SIZE-1:0]));
      end
    end
  end

  initial begin
    logic [3:0] rx [7] = '{4'd5, 4'd0, 4'd2, 4'd2, 4'd2, 4'd2, 4'd2};
    logic [3:0] ry [7] = '{4'd0, 4'd7, 4'd3, 4'd1, 4'd2, 4'd2, 4'd2};
    logic [3:0] rz [7] = '{4'd0, 4'd7, 4'd0, 4'd9, 4'd3, 4'd1, 4'd2};
    logic [2:0] rr [7] = '{3'd1, 3'd4, 3'd2, 3'd5, 3'd3, 3'd6, 3'd7};
    bus.in_valid = 1'b0;
    bus.in = '0;
    bus.sw_avail = 1'b0;
    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b0);
    rst = 1'b0;
    step(1'b0, '0, 1'b0);
    chk("rst_out_valid", 96'(bus.out_valid), 96'(0));
    chk("rst_in_ready", 96'(bus.in_ready), 96'(1));
    chk("rst_count", 96'(bus.count), 96'(0));
    chk("rst_ovf", 96'(bus.ovf_err), 96'(0));
    for (int i = 0; i < 3; i++) step(1'b1, mk(4'd2, 4'd2, 4'd2, 16'(100 + i)), 1'b0);
    chk("mid_count_before", 96'(bus.count), 96'(3));
    rst = 1'b1;
    step(1'b1, mk(4'd3, 4'd2, 4'd2, 16'd199), 1'b1);
    rst = 1'b0;
    step(1'b0, '0, 1'b0);
    chk("mid_rst_count", 96'(bus.count), 96'(0));
    chk("mid_rst_out_valid", 96'(bus.out_valid), 96'(0));
    chk("mid_rst_ovf", 96'(bus.ovf_err), 96'(0));
    for (int i = 0; i < 7; i++) begin
      send(mk(rx[i], ry[i], rz[i], 16'(i)), rr[i], 1'b1);
      if (i == 0) begin
        chk("latency_out_valid", 96'(bus.out_valid), 96'(1));
        chk("latency_count", 96'(bus.count), 96'(1));
      end
    end
    step(1'b0, '0, 1'b1);
    chk("route_drain_count", 96'(bus.count), 96'(0));
    send(mk(4'd2, 4'd2, 4'd2, 16'd40), 3'd7, 1'b0);
    send(mk(4'd1, 4'd2, 4'd2, 16'd41), 3'd4, 1'b0);
    chk("pair_count_before", 96'(bus.count), 96'(2));
    send(mk(4'd2, 4'd2, 4'd5, 16'd42), 3'd3, 1'b1);
    chk("pair_count_after", 96'(bus.count), 96'(2));
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);
    chk("pair_drain_count", 96'(bus.count), 96'(0));
    step(1'b0, '0, 1'b1);
    chk("empty_grant_count", 96'(bus.count), 96'(0));
    chk("empty_grant_valid", 96'(bus.out_valid), 96'(0));
    for (int i = 0; i < 5; i++) send(mk(4'd2, 4'd2, 4'd2, 16'(20 + i)), 3'd7, 1'b0);
    chk("full_count", 96'(bus.count), 96'(5));
    chk("full_in_ready", 96'(bus.in_ready), 96'(0));
    step(1'b1, mk(4'd3, 4'd2, 4'd2, 16'd29), 1'b1);
    chk("full_pop_only_count", 96'(bus.count), 96'(4));
    chk("full_pop_only_ovf", 96'(bus.ovf_err), 96'(0));
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1);
    chk("full_drain_count", 96'(bus.count), 96'(0));
    for (int i = 0; i < 5; i++) send(mk(4'd0, 4'd9, 4'd2, 16'(30 + i)), 3'd4, 1'b0);
    chk("fill_count", 96'(bus.count), 96'(5));
    chk("fill_in_ready", 96'(bus.in_ready), 96'(0));
    chk("fill_ovf_before", 96'(bus.ovf_err), 96'(0));
    step(1'b1, mk(4'd3, 4'd3, 4'd3, 16'd35), 1'b0);
    chk("ovf_set", 96'(bus.ovf_err), 96'(1));
    chk("ovf_count", 96'(bus.count), 96'(5));
    for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1);
    chk("ovf_drain_count", 96'(bus.count), 96'(0));
    chk("ovf_sticky", 96'(bus.ovf_err), 96'(1));
    for (int i = 0; i < 12; i++) send(mk(4'd2, 4'd2, 4'd0, 16'(i)), 3'd6, 1'b1);
    step(1'b0, '0, 1'b1);
    chk("wrap_count", 96'(bus.count), 96'(0));
    step(1'b0, '0, 1'b0);
    chk("sb_empty", 96'(sb.size()), 96'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
